// File: rtl/line_decoder_pkg.sv
// rtl/line_decoder_pkg.sv - shared widths, line vector type and decode helper
package line_decoder_pkg;

   localparam int SEL_W = 3;
   localparam int OUT_W = 8;

   typedef logic [OUT_W-1:0] line_vec_t;

   // MSB-first one-hot: index 0 lights the top line, index 7 the bottom line
   function automatic line_vec_t decode_msb_first(input logic en, input logic [SEL_W-1:0] idx);
      line_vec_t v;
      v = '0;
      if (en) begin
         v = line_vec_t'(8'h80) >> idx;
      end
      return v;
   endfunction

endpackage

// File: rtl/line_decoder_if.sv
// rtl/line_decoder_if.sv - select inputs and decoded line outputs of line_decoder
interface line_decoder_if;
   import line_decoder_pkg::*;

   logic      Enable;
   logic      A;
   logic      B;
   logic      C;
   logic      clr_hist;
   line_vec_t F;
   line_vec_t F_q;
   line_vec_t hist;

   modport master (
      output Enable, A, B, C, clr_hist,
      input  F, F_q, hist
   );

   modport slave (
      input  Enable, A, B, C, clr_hist,
      output F, F_q, hist
   );

endinterface

// File: rtl/line_decoder_core.sv
// rtl/line_decoder_core.sv - purely combinational 3-to-8 MSB-first decode
import line_decoder_pkg::*;

module line_decoder_core (
   input  logic             en,
   input  logic [SEL_W-1:0] idx,
   output line_vec_t        f
);

   // Decode is independent of clock and reset so it stays valid during reset
   always_comb begin
      f = '0;
      f = decode_msb_first(en, idx);
   end

endmodule

// File: rtl/line_decoder.sv
// rtl/line_decoder.sv - decoder top with registered copy and sticky history mask
import line_decoder_pkg::*;

module line_decoder (
   input  logic          clk,
   input  logic          rst_n,
   line_decoder_if.slave bus
);

   logic [SEL_W-1:0] idx;
   line_vec_t        f_comb;
   line_vec_t        f_q_r;
   line_vec_t        hist_r;

   assign idx = {bus.A, bus.B, bus.C};

   line_decoder_core u_core (
      .en  (bus.Enable),
      .idx (idx),
      .f   (f_comb)
   );

   // Registered copy of the decode for glitch-free downstream sampling
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_q_r <= '0;
      end else begin
         f_q_r <= f_comb;
      end
   end

   // Sticky history of registered lines; a clear wins and drops the current F_q
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_r <= '0;
      end else if (bus.clr_hist) begin
         hist_r <= '0;
      end else begin
         hist_r <= hist_r | f_q_r;
      end
   end

   assign bus.F    = f_comb;
   assign bus.F_q  = f_q_r;
   assign bus.hist = hist_r;

endmodule

// File: tb/tb_line_decoder.sv
// tb/tb_line_decoder.sv - scoreboard bench for line_decoder
module tb_line_decoder;

   typedef struct {
      string      tag;
      logic [7:0] fq;
      logic [7:0] hist;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   exp_t sb_q[$];
   logic [7:0] m_fq;
   logic [7:0] m_hist;

   line_decoder_if dif ();

   line_decoder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (dif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] ref_decode(input logic en, input logic [2:0] idx);
      logic [7:0] v;
      v = 8'h00;
      if (en) v[3'd7 - idx] = 1'b1;
      return v;
   endfunction

   task automatic drive(input logic en, input logic [2:0] idx, input logic clr);
      dif.Enable   = en;
      dif.A        = idx[2];
      dif.B        = idx[1];
      dif.C        = idx[0];
      dif.clr_hist = clr;
   endtask

   // Drive one cycle of stimulus, check F combinationally, then check registers after the edge
   task automatic cycle(input logic en, input logic [2:0] idx, input logic clr, input string tag);
      exp_t e;
      exp_t got;
      logic [7:0] ef;
      drive(en, idx, clr);
      #1;
      ef = ref_decode(en, idx);
      check_val({tag, "_F"}, dif.F, ef);
      m_hist = clr ? 8'h00 : (m_hist | m_fq);
      m_fq   = ef;
      e.tag  = tag;
      e.fq   = m_fq;
      e.hist = m_hist;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check_val({tag, "_sb_empty"}, 8'h01, 8'h00);
      end else begin
         got = sb_q.pop_front();
         check_val({got.tag, "_Fq"}, dif.F_q, got.fq);
         check_val({got.tag, "_hist"}, dif.hist, got.hist);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      m_fq     = 8'h00;
      m_hist   = 8'h00;
      rst_n    = 1'b0;
      drive(1'b1, 3'd0, 1'b0);

      // Combinational decode with no dependence on clock or reset
      #5;
      check_val("rst_F_idx0", dif.F, 8'h80);
      check_val("rst_Fq", dif.F_q, 8'h00);
      check_val("rst_hist", dif.hist, 8'h00);

      @(negedge clk);
      rst_n = 1'b1;

      // Enabled sweep, MSB-first
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, 3'(i), 1'b0, $sformatf("en_idx%0d", i));
      end

      // Disabled sweep: F and F_q zero, hist only absorbs the last enabled F_q
      for (int i = 0; i < 8; i++) begin
         cycle(1'b0, 3'(i), 1'b0, $sformatf("dis_idx%0d", i));
      end

      // Clear, then idx 2 then 6 builds hist 8'h22
      cycle(1'b0, 3'd0, 1'b1, "clr_a");
      cycle(1'b1, 3'd2, 1'b0, "seq_2");
      cycle(1'b1, 3'd6, 1'b0, "seq_6");
      cycle(1'b0, 3'd0, 1'b0, "seq_hist");
      check_val("seq_hist_22", dif.hist, 8'h22);

      // Clear with idx 0 enabled: hist zero on that edge, 8'h80 on the next
      cycle(1'b1, 3'd0, 1'b1, "clr_pulse");
      check_val("clr_pulse_hist0", dif.hist, 8'h00);
      cycle(1'b1, 3'd0, 1'b0, "clr_after");
      check_val("clr_after_hist80", dif.hist, 8'h80);

      // Fill hist to 8'hFF and leave F_q at 8'h10
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, 3'(i), 1'b0, $sformatf("fill_idx%0d", i));
      end
      cycle(1'b1, 3'd3, 1'b0, "pre_rst");
      check_val("pre_rst_Fq10", dif.F_q, 8'h10);
      check_val("pre_rst_histFF", dif.hist, 8'hFF);

      // Asynchronous reset between edges
      #2;
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_Fq", dif.F_q, 8'h00);
      check_val("mid_rst_hist", dif.hist, 8'h00);
      check_val("mid_rst_F", dif.F, 8'h10);
      drive(1'b1, 3'd5, 1'b0);
      #1;
      check_val("mid_rst_F_track", dif.F, 8'h04);
      #1;
      rst_n  = 1'b1;
      m_fq   = 8'h00;
      m_hist = 8'h00;
      cycle(1'b1, 3'd5, 1'b0, "post_rst_a");
      cycle(1'b1, 3'd7, 1'b0, "post_rst_b");
      cycle(1'b0, 3'd7, 1'b0, "post_rst_c");

      check_val("sb_drained", 8'(sb_q.size()), 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
